// File: rtl/instr_fetch.sv
// Instruction fetch: PC and IR registers feeding the control FSM, plus fetch bookkeeping flags.
// Latency: 1 cycle for PC/IR/flags; IMem_addr is combinational from next PC. Never stalls.
module instr_fetch #(
   parameter int                ADDR_W   = 7,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              Clk,
   input  logic              ResetN,
   input  logic              PC_clr,
   input  logic              PC_up,
   input  logic              IR_ld,
   output logic [ADDR_W-1:0] IMem_addr,
   input  logic [15:0]       IMem_data,
   output logic [15:0]       IR,
   output logic [ADDR_W-1:0] PC,
   output logic              IR_valid,
   output logic              Halt_seen,
   output logic [15:0]       Fetch_cnt
);

   localparam logic [3:0]  OP_HALT = 4'd5;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   logic [ADDR_W-1:0] pc_d, pc_q;
   logic [15:0]       ir_d, ir_q;
   logic              ir_valid_d, ir_valid_q;
   logic              halt_seen_d, halt_seen_q;
   logic [15:0]       fetch_cnt_d, fetch_cnt_q;

   always_comb begin
      pc_d        = pc_q;
      ir_d        = ir_q;
      ir_valid_d  = ir_valid_q;
      halt_seen_d = halt_seen_q;
      fetch_cnt_d = fetch_cnt_q;

      if (PC_clr) begin
         pc_d = RESET_PC;
      end else if (PC_up) begin
         pc_d = pc_q + ADDR_W'(1);
      end

      // IR always captures the word at the old PC; PC_clr only overrides the flags
      if (IR_ld) begin
         ir_d = IMem_data;
         if (fetch_cnt_q != CNT_MAX) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
         end
      end

      if (PC_clr) begin
         ir_valid_d  = 1'b0;
         halt_seen_d = 1'b0;
      end else if (IR_ld) begin
         ir_valid_d  = 1'b1;
         halt_seen_d = (IMem_data[15:12] == OP_HALT);
      end
   end

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         pc_q        <= RESET_PC;
         ir_q        <= 16'h0000;
         ir_valid_q  <= 1'b0;
         halt_seen_q <= 1'b0;
         fetch_cnt_q <= 16'h0000;
      end else begin
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         ir_valid_q  <= ir_valid_d;
         halt_seen_q <= halt_seen_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   // Hold the memory on RESET_PC during reset so the first post-reset fetch sees mem[RESET_PC]
   assign IMem_addr = ResetN ? pc_d : RESET_PC;
   assign IR        = ir_q;
   assign PC        = pc_q;
   assign IR_valid  = ir_valid_q;
   assign Halt_seen = halt_seen_q;
   assign Fetch_cnt = fetch_cnt_q;

endmodule
